// File: rtl/div_pkg.sv
// Shared definitions for the multicycle signed divider: FSM states and sizing defaults.
package div_pkg;

  localparam int DIV_W = 32;
  localparam int CNT_W = $clog2(DIV_W);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FIX    = 2'd2,
    FINISH = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_abs_neg.sv
// Conditional two's-complement negate; used both to take operand magnitudes and to restore result signs.
module div_abs_neg
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic [WIDTH-1:0] val_i,
  input  logic             neg_i,
  output logic [WIDTH-1:0] res_o
);

  assign res_o = neg_i ? -val_i : val_i;

endmodule

// File: rtl/seq_divider.sv
// Multicycle signed restoring divider (DIV): quotient on lo_out, remainder on hi_out.
// Optional DIV_SHORTCUT_EN: finish early when |a| < |b|, with identical results.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             busy,
  output logic             done,
  output logic             div_zero
);

  localparam int CW = (WIDTH == DIV_W) ? CNT_W : $clog2(WIDTH);

  div_state_e        state_q, state_d;
  logic [WIDTH:0]    rem_q, rem_d;
  logic [WIDTH-1:0]  quo_q, quo_d;
  logic [WIDTH-1:0]  dvs_q, dvs_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              sign_a_q, sign_a_d;
  logic              sign_q_q, sign_q_d;
  logic [WIDTH-1:0]  hi_q, hi_d;
  logic [WIDTH-1:0]  lo_q, lo_d;
  logic              done_q, done_d;
  logic              dz_q, dz_d;

  logic [WIDTH-1:0]  abs_a, abs_b;
  logic [WIDTH-1:0]  fix_quo, fix_rem;
  logic [WIDTH:0]    shifted;
  logic signed [WIDTH:0] trial;

  div_abs_neg #(.WIDTH(WIDTH)) u_abs_a (.val_i(a), .neg_i(a[WIDTH-1]), .res_o(abs_a));
  div_abs_neg #(.WIDTH(WIDTH)) u_abs_b (.val_i(b), .neg_i(b[WIDTH-1]), .res_o(abs_b));
  div_abs_neg #(.WIDTH(WIDTH)) u_fix_q (.val_i(quo_q), .neg_i(sign_q_q), .res_o(fix_quo));
  div_abs_neg #(.WIDTH(WIDTH)) u_fix_r (.val_i(rem_q[WIDTH-1:0]), .neg_i(sign_a_q), .res_o(fix_rem));

  // One restoring step: bring in the next dividend bit, then trial-subtract the divisor.
  assign shifted = (rem_q << 1) | {{WIDTH{1'b0}}, quo_q[WIDTH-1]};
  assign trial   = shifted - {1'b0, dvs_q};

  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    cnt_d    = cnt_q;
    sign_a_d = sign_a_q;
    sign_q_d = sign_q_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    done_d   = done_q;
    dz_d     = dz_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          sign_a_d = a[WIDTH-1];
          sign_q_d = a[WIDTH-1] ^ b[WIDTH-1];
          quo_d    = abs_a;
          dvs_d    = abs_b;
          rem_d    = '0;
          cnt_d    = '0;
          if (b == '0) begin
            dz_d    = 1'b1;
            state_d = FINISH;
          end else begin
            dz_d    = 1'b0;
`ifdef DIV_SHORTCUT_EN
            if (abs_a < abs_b) begin
              lo_d    = '0;
              hi_d    = a;
              state_d = FINISH;
            end else begin
              state_d = CALC;
            end
`else
            state_d = CALC;
`endif
          end
        end
      end

      CALC: begin
        if (trial >= 0) begin
          rem_d = trial;
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted;
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = FIX;
        end
      end

      FIX: begin
        lo_d    = fix_quo;
        hi_d    = fix_rem;
        done_d  = 1'b1;
        state_d = FINISH;
      end

      FINISH: begin
        // Early exits arrive here with done low; raise it for one cycle before leaving.
        if (done_q) begin
          done_d  = 1'b0;
          state_d = IDLE;
        end else begin
          done_d  = 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      cnt_q    <= '0;
      sign_a_q <= 1'b0;
      sign_q_q <= 1'b0;
      hi_q     <= '0;
      lo_q     <= '0;
      done_q   <= 1'b0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      cnt_q    <= cnt_d;
      sign_a_q <= sign_a_d;
      sign_q_q <= sign_q_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      done_q   <= done_d;
      dz_q     <= dz_d;
    end
  end

  assign hi_out   = hi_q;
  assign lo_out   = lo_q;
  assign busy     = (state_q != IDLE);
  assign done     = done_q;
  assign div_zero = dz_q;

endmodule

// File: tb/tb_seq_divider.sv
// Directed and randomized checks of seq_divider against an arithmetic reference model.
module tb_seq_divider;

  logic        clock;
  logic        reset;
  logic        start;
  logic [31:0] a, b;
  logic [31:0] hi_out, lo_out;
  logic        busy, done, div_zero;

  int checks = 0;
  int errors = 0;

  // Model state: outputs hold their values across divide-by-zero operations.
  logic [31:0] exp_hi = '0;
  logic [31:0] exp_lo = '0;

  seq_divider #(.WIDTH(32)) dut (
    .clock(clock), .reset(reset), .start(start), .a(a), .b(b),
    .hi_out(hi_out), .lo_out(lo_out), .busy(busy), .done(done), .div_zero(div_zero)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mag(input logic [31:0] v);
    return v[31] ? (~v + 32'd1) : v;
  endfunction

  function automatic int exp_latency(input logic [31:0] av, input logic [31:0] bv);
    if (bv == 32'd0) return 1;
`ifdef DIV_SHORTCUT_EN
    if (mag(av) < mag(bv)) return 1;
`endif
    return 33;
  endfunction

  // Truncating signed division via 64-bit arithmetic; updates the expected outputs.
  task automatic model(input logic [31:0] av, input logic [31:0] bv);
    longint la, lb, q, r;
    if (bv == 32'd0) return;
    la = longint'($signed(av));
    lb = longint'($signed(bv));
    q = la / lb;
    r = la % lb;
    exp_lo = q[31:0];
    exp_hi = r[31:0];
  endtask

  // Issue one op; optionally pulse start with another op at edge pulse_at (should be ignored).
  task automatic run_op(input string tag, input logic [31:0] av, input logic [31:0] bv,
                        input int pulse_at, input logic [31:0] pa, input logic [31:0] pb);
    int lat;
    int want;
    lat = -1;
    want = exp_latency(av, bv);
    @(negedge clock);
    a = av; b = bv; start = 1'b1;
    @(posedge clock);
    #1;
    check({tag, "_busy_e0"}, {31'd0, busy}, 32'd1);
    @(negedge clock);
    start = 1'b0;
    a = $urandom; b = $urandom;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      if (k == pulse_at) begin
        start = 1'b1; a = pa; b = pb;
      end else begin
        start = 1'b0;
      end
      @(posedge clock);
      #1;
      if (done) lat = k;
      @(negedge clock);
    end
    start = 1'b0;
    model(av, bv);
    check({tag, "_latency"}, lat, want);
    check({tag, "_lo"}, lo_out, exp_lo);
    check({tag, "_hi"}, hi_out, exp_hi);
    check({tag, "_dz"}, {31'd0, div_zero}, {31'd0, bv == 32'd0});
    @(posedge clock);
    #1;
    check({tag, "_done_pulse"}, {31'd0, done}, 32'd0);
    check({tag, "_idle"}, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int lat;
    logic [31:0] ra, rb;
    reset = 1'b1; start = 1'b0; a = '0; b = '0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_hi", hi_out, 32'd0);
    check("rst_lo", lo_out, 32'd0);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_dz", {31'd0, div_zero}, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    run_op("p100_7", 32'd100, 32'd7, 0, '0, '0);
    check("p100_7_lo_const", lo_out, 32'd14);
    check("p100_7_hi_const", hi_out, 32'd2);
    run_op("n100_7", -32'sd100, 32'd7, 0, '0, '0);
    check("n100_7_lo_const", lo_out, 32'hFFFF_FFF2);
    check("n100_7_hi_const", hi_out, 32'hFFFF_FFFE);
    run_op("p100_n7", 32'd100, -32'sd7, 0, '0, '0);
    check("p100_n7_hi_const", hi_out, 32'd2);
    run_op("ovf", 32'h8000_0000, 32'hFFFF_FFFF, 0, '0, '0);
    check("ovf_lo_const", lo_out, 32'h8000_0000);
    run_op("p100_7b", 32'd100, 32'd7, 0, '0, '0);
    run_op("dz5", 32'd5, 32'd0, 0, '0, '0);
    check("dz5_lo_kept", lo_out, 32'd14);
    check("dz5_hi_kept", hi_out, 32'd2);
    run_op("ignore", 32'd100, 32'd7, 10, 32'd9, 32'd3);
    check("ignore_lo_const", lo_out, 32'd14);
    run_op("p3_10", 32'd3, 32'd10, 0, '0, '0);
    check("p3_10_hi_const", hi_out, 32'd3);

    // Reset sampled at E10 of an op aborts it.
    @(negedge clock);
    a = 32'd1000; b = 32'd3; start = 1'b1;
    @(posedge clock);
    @(negedge clock);
    start = 1'b0;
    repeat (9) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_done", {31'd0, done}, 32'd0);
    check("abort_hi", hi_out, 32'd0);
    check("abort_lo", lo_out, 32'd0);
    check("abort_dz", {31'd0, div_zero}, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    exp_hi = '0; exp_lo = '0;

    // Start held high: next op accepted on the first IDLE edge after FINISH.
    a = 32'd20; b = 32'd3; start = 1'b1;
    lat = -1;
    for (int k = 0; k <= 40 && lat < 0; k++) begin
      @(posedge clock);
      #1;
      if (done) lat = k;
    end
    check("held_latency", lat, exp_latency(32'd20, 32'd3));
    @(posedge clock);
    #1;
    check("held_idle_gap", {31'd0, busy}, 32'd0);
    @(posedge clock);
    #1;
    check("held_reaccept", {31'd0, busy}, 32'd1);
    @(negedge clock);
    start = 1'b0;
    lat = -1;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      @(posedge clock);
      #1;
      if (done) lat = k;
    end
    model(32'd20, 32'd3);
    check("held2_lo", lo_out, exp_lo);
    check("held2_hi", hi_out, exp_hi);
    @(posedge clock);

    for (int i = 0; i < 24; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 4))
        0: rb = 32'd0;
        1: rb = $urandom_range(1, 20);
        2: begin ra = $urandom_range(0, 50); rb = $urandom_range(51, 5000); end
        3: rb = -$urandom_range(1, 1000);
        default: ;
      endcase
      if ($urandom_range(0, 1) == 1) ra = -ra;
      run_op("rand", ra, rb, $urandom_range(2, 30), $urandom, $urandom);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
